// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared constants for the UART transmit scheduler slice:
//   - UART_DATA_W      : byte width of the transmitter data port
//   - DEFAULT_NUM_REQ  : default number of requesters sharing one transmitter
//   - ST_IDLE/LOAD/SEND: scheduler state encoding
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker. Selects the first asserted request at or
// after rr_ptr, wrapping modulo NUM_REQ.
// Ports:
//   req        in  NUM_REQ  request vector
//   rr_ptr     in  IDX_W    highest-priority index this round
//   win_onehot out NUM_REQ  one-hot winner (all-zero when no request)
//   win_idx    out IDX_W    index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx
);

  logic found;
  int   j;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    j          = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found         = 1'b1;
        win_onehot[j] = 1'b1;
        win_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ requesters. A requester is granted
// round-robin and keeps the transmitter for its whole multi-byte message; its
// bytes are fed one at a time over the data/data_valid/tx_busy handshake.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   req            per-requester byte available
//   req_data       byte of requester i at [i*DATA_W +: DATA_W]
//   req_last       current byte closes the message
//   req_ack        one-cycle pulse to the owner: byte taken
//   grant          one-hot current owner, zero when idle
//   tx_data        byte to the transmitter
//   tx_data_valid  data_valid to the transmitter
//   tx_busy        transmitter busy (baud domain, synchronised here)
//   sched_busy     scheduler is not idle
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_data_valid,
  input  logic                      tx_busy,
  output logic                      sched_busy
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic              busy_meta_p0;
  logic              busy_s;
  logic [1:0]        warm;
  logic [1:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              last_q;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx)
  );

  assign sched_busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_meta_p0  <= 1'b0;
      busy_s        <= 1'b0;
      warm          <= 2'b00;
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      last_q        <= 1'b0;
      grant         <= '0;
      req_ack       <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      // Stage boundary: tx_busy crosses in through two flops.
      busy_meta_p0 <= tx_busy;
      busy_s       <= busy_meta_p0;
      // The synchroniser flops restart at 0 after reset, so busy_s reads
      // "idle" for two edges even if the transmitter is mid-frame. warm
      // holds off new grants until busy_s reflects the real tx_busy.
      warm         <= {warm[0], 1'b1};
      req_ack      <= '0;

      // Stage boundary: scheduler decisions on busy_s.
      case (state)
        ST_IDLE: begin
          if ((|req) && !busy_s && warm[1]) begin
            grant         <= pick_onehot;
            owner         <= pick_idx;
            tx_data       <= req_bytes[pick_idx];
            last_q        <= req_last[pick_idx];
            tx_data_valid <= 1'b1;
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Dropping valid as soon as busy is seen keeps the transmitter from
          // picking the same byte up again at the end of its frame.
          if (busy_s) begin
            tx_data_valid <= 1'b0;
            req_ack       <= grant;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!busy_s) begin
            // A requester that withdrew req ends its message here as if the
            // byte just sent had been flagged last.
            if (last_q || !req[owner]) begin
              grant  <= '0;
              rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
              state  <= ST_IDLE;
            end else begin
              tx_data       <= req_bytes[owner];
              last_q        <= req_last[owner];
              tx_data_valid <= 1'b1;
              state         <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  import uart_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int B    = 4;   // clk cycles per serial bit in the transmitter model

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NREQ-1:0]   req, req_last, req_ack, grant;
  logic [NREQ*8-1:0] req_data;
  logic [7:0]        tx_data;
  logic              tx_data_valid, sched_busy;
  logic              tx_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_busy       (tx_busy),
    .sched_busy    (sched_busy)
  );

  // Transmitter model: latches a byte on data_valid when idle, then shifts
  // start + 8 data (LSB first) + stop, B clocks per bit. Not reset by rst.
  logic [9:0] txm_sh   = 10'h3FF;
  int         txm_bit  = 0;
  int         txm_clk  = 0;
  int         sent_total = 0;
  logic       tx_line;
  assign tx_line = tx_busy ? txm_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (!tx_busy) begin
      if (tx_data_valid === 1'b1) begin
        tx_busy    <= 1'b1;
        txm_sh     <= {1'b1, tx_data, 1'b0};
        txm_bit    <= 0;
        txm_clk    <= 0;
        sent_total <= sent_total + 1;
      end
    end else if (txm_clk == B - 1) begin
      txm_clk <= 0;
      txm_sh  <= {1'b1, txm_sh[9:1]};
      if (txm_bit == 9) tx_busy <= 1'b0;
      else              txm_bit <= txm_bit + 1;
    end else begin
      txm_clk <= txm_clk + 1;
    end
  end

  // Monitors (negedge): serial decoder and running statistics.
  logic [7:0] rx_log [$];
  logic       rx_act    = 1'b0;
  int         rcnt      = 0;
  logic [7:0] rsh       = 8'h00;
  int         frame_err = 0;
  int         ack_total [NREQ] = '{0, 0, 0, 0};
  int         viol      = 0;
  int         vrise     = 0;
  int         lowrun    = 0;
  int         last_gap  = 0;
  logic       prev_v    = 1'b0;
  logic [7:0] prev_d    = 8'h00;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (req_ack[i] === 1'b1) ack_total[i] <= ack_total[i] + 1;
    if (((req_ack & ~grant) != '0) || !$onehot0(grant) ||
        (tx_data_valid && prev_v && (tx_data !== prev_d)))
      viol <= viol + 1;
    prev_v <= tx_data_valid;
    prev_d <= tx_data;
    if (tx_data_valid && !prev_v) begin
      vrise    <= vrise + 1;
      last_gap <= lowrun;
    end
    if (tx_data_valid) lowrun <= 0;
    else               lowrun <= lowrun + 1;
    if (!rx_act) begin
      if (tx_line == 1'b0) begin
        rx_act <= 1'b1;
        rcnt   <= 1;
      end
    end else begin
      if ((rcnt % B == B / 2) && (rcnt > B) && (rcnt < 9 * B))
        rsh <= {tx_line, rsh[7:1]};
      if (rcnt == 9 * B + B / 2) begin
        if (tx_line) rx_log.push_back(rsh);
        else         frame_err <= frame_err + 1;
        rx_act <= 1'b0;
      end
      rcnt <= rcnt + 1;
    end
  end

  // Requester model: presents the head of its queue; pops on req_ack.
  logic [7:0] msg_q [NREQ][$];
  int         drop_at  [NREQ];
  int         drv_acks [NREQ];

  initial begin
    req      = '0;
    req_last = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      drop_at[i]  = -1;
      drv_acks[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] === 1'b1 && msg_q[i].size() > 0) begin
          void'(msg_q[i].pop_front());
          drv_acks[i] = drv_acks[i] + 1;
          if (drop_at[i] == drv_acks[i]) msg_q[i].delete();
        end
        if (msg_q[i].size() > 0) begin
          req[i]            = 1'b1;
          req_data[i*8 +: 8] = msg_q[i][0];
          req_last[i]       = (msg_q[i].size() == 1);
        end else begin
          req[i]            = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int stable;
    int n;
    bit qs;
    stable = 0;
    n = 0;
    while (stable < 8 && n < 3000) begin
      @(negedge clk);
      n++;
      qs = 1'b1;
      for (int i = 0; i < NREQ; i++) if (msg_q[i].size() != 0) qs = 1'b0;
      if (qs && !sched_busy && !tx_busy && !rx_act) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 8) begin
      errors++;
      $display("FAIL %s_idle_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL reset_req_ack got %b want 0000", req_ack); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_data_valid got %b want 0", tx_data_valid); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_sched_busy got %b want 0", sched_busy); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, ST_IDLE); end
    checks++; if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int rb, ab, ao;
    logic [7:0] exp [5];
    logic [7:0] got;
    exp = '{8'h54, 8'h41, 8'h4D, 8'h49, 8'h4D};  // "TAMIM"
    rb = rx_log.size();
    ab = ack_total[0];
    ao = ack_total[1] + ack_total[2] + ack_total[3];
    @(negedge clk);
    for (int k = 0; k < 5; k++) msg_q[0].push_back(exp[k]);
    wait_idle("single");
    checks++; if (rx_log.size() - rb != 5) begin errors++; $display("FAIL single_count got %0d bytes want 5", rx_log.size() - rb); end
    for (int k = 0; k < 5; k++) begin
      got = (rb + k < rx_log.size()) ? rx_log[rb + k] : 8'hxx;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL single_byte%0d got %h want %h", k, got, exp[k]); end
    end
    checks++; if (ack_total[0] - ab != 5) begin errors++; $display("FAIL single_acks got %0d want 5", ack_total[0] - ab); end
    checks++; if (ack_total[1] + ack_total[2] + ack_total[3] - ao != 0) begin errors++; $display("FAIL single_other_acks got %0d want 0", ack_total[1] + ack_total[2] + ack_total[3] - ao); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_grant got %b want 0000", grant); end
    checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL single_rr_ptr got %0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_contention();
    int rb;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [5];
    logic [7:0] got;
    exp1 = '{8'hA0, 8'hA1, 8'hC0, 8'hC1};
    exp2 = '{8'h5A, 8'hC0, 8'hC1, 8'hA0, 8'hA1};
    do_reset();
    rb = rx_log.size();
    msg_q[0].push_back(8'hA0); msg_q[0].push_back(8'hA1);
    msg_q[2].push_back(8'hC0); msg_q[2].push_back(8'hC1);
    wait_idle("contend1");
    checks++; if (rx_log.size() - rb != 4) begin errors++; $display("FAIL contend1_count got %0d want 4", rx_log.size() - rb); end
    for (int k = 0; k < 4; k++) begin
      got = (rb + k < rx_log.size()) ? rx_log[rb + k] : 8'hxx;
      checks++; if (got !== exp1[k]) begin errors++; $display("FAIL contend1_byte%0d got %h want %h", k, got, exp1[k]); end
    end
    checks++; if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL contend1_rr_ptr got %0d want 3", dut.rr_ptr); end
    // Second round starting from rr_ptr=1: requester 2 goes first.
    do_reset();
    rb = rx_log.size();
    msg_q[0].push_back(8'h5A);
    wait_idle("contend_prep");
    @(negedge clk);
    msg_q[0].push_back(8'hA0); msg_q[0].push_back(8'hA1);
    msg_q[2].push_back(8'hC0); msg_q[2].push_back(8'hC1);
    wait_idle("contend2");
    checks++; if (rx_log.size() - rb != 5) begin errors++; $display("FAIL contend2_count got %0d want 5", rx_log.size() - rb); end
    for (int k = 0; k < 5; k++) begin
      got = (rb + k < rx_log.size()) ? rx_log[rb + k] : 8'hxx;
      checks++; if (got !== exp2[k]) begin errors++; $display("FAIL contend2_byte%0d got %h want %h", k, got, exp2[k]); end
    end
    checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL contend2_rr_ptr got %0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_early_drop();
    int rb, ab;
    logic [7:0] got;
    rb = rx_log.size();
    ab = ack_total[1];
    @(negedge clk);
    drop_at[1] = drv_acks[1] + 2;
    msg_q[1].push_back(8'h31); msg_q[1].push_back(8'h32);
    msg_q[1].push_back(8'h33); msg_q[1].push_back(8'h34);
    wait_idle("drop");
    drop_at[1] = -1;
    checks++; if (rx_log.size() - rb != 2) begin errors++; $display("FAIL drop_count got %0d want 2", rx_log.size() - rb); end
    got = (rb + 1 < rx_log.size()) ? rx_log[rb + 1] : 8'hxx;
    checks++; if (got !== 8'h32) begin errors++; $display("FAIL drop_byte1 got %h want 32", got); end
    checks++; if (ack_total[1] - ab != 2) begin errors++; $display("FAIL drop_acks got %0d want 2", ack_total[1] - ab); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL drop_state got %0d want %0d", dut.state, ST_IDLE); end
    checks++; if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL drop_rr_ptr got %0d want 2", dut.rr_ptr); end
  endtask

  task automatic test_reset_load();
    int rb, ab, n, lr;
    logic [7:0] exp [4];
    logic [7:0] got;
    exp = '{8'h11, 8'h11, 8'h22, 8'h33};
    rb = rx_log.size();
    ab = ack_total[0];
    @(negedge clk);
    msg_q[0].push_back(8'h11); msg_q[0].push_back(8'h22); msg_q[0].push_back(8'h33);
    n = 0;
    while (!(dut.state == ST_LOAD && tx_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL rstload_reach_load timeout after %0d cycles, required LOAD with tx_busy", n); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rstload_grant got %b want 0000", grant); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rstload_valid got %b want 0", tx_data_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstload_tx_data got %h want 00", tx_data); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL rstload_sched_busy got %b want 0", sched_busy); end
    checks++; if (ack_total[0] - ab != 0) begin errors++; $display("FAIL rstload_no_ack got %0d want 0", ack_total[0] - ab); end
    // tx_busy is still high here; valid may only return once busy_s is low.
    n = 0;
    lr = 0;
    while (!tx_data_valid && n < 200) begin
      if (tx_busy) lr = 0;
      else         lr++;
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL rstload_restart timeout after %0d cycles, required new valid", n); end
    checks++; if (lr < 3) begin errors++; $display("FAIL rstload_busy_gate idle cycles before valid got %0d want >=3", lr); end
    wait_idle("rstload");
    checks++; if (rx_log.size() - rb != 4) begin errors++; $display("FAIL rstload_count got %0d want 4", rx_log.size() - rb); end
    for (int k = 0; k < 4; k++) begin
      got = (rb + k < rx_log.size()) ? rx_log[rb + k] : 8'hxx;
      checks++; if (got !== exp[k]) begin errors++; $display("FAIL rstload_byte%0d got %h want %h", k, got, exp[k]); end
    end
    checks++; if (ack_total[0] - ab != 3) begin errors++; $display("FAIL rstload_acks got %0d want 3", ack_total[0] - ab); end
    checks++; if (dut.rr_ptr !== 2'd1) begin errors++; $display("FAIL rstload_rr_ptr got %0d want 1", dut.rr_ptr); end
  endtask

  task automatic test_wrap();
    int who [3];
    logic [1:0] rr_exp [3];
    logic [7:0] val [3];
    int rb;
    logic [7:0] got;
    who    = '{2, 3, 0};
    rr_exp = '{2'd3, 2'd0, 2'd1};
    val    = '{8'h72, 8'h73, 8'h70};
    for (int t = 0; t < 3; t++) begin
      rb = rx_log.size();
      @(negedge clk);
      msg_q[who[t]].push_back(val[t]);
      wait_idle("wrap");
      got = (rb < rx_log.size()) ? rx_log[rb] : 8'hxx;
      checks++; if (got !== val[t]) begin errors++; $display("FAIL wrap%0d_byte got %h want %h", t, got, val[t]); end
      checks++; if (dut.rr_ptr !== rr_exp[t]) begin errors++; $display("FAIL wrap%0d_rr_ptr got %0d want %0d", t, dut.rr_ptr, rr_exp[t]); end
    end
  endtask

  task automatic test_back_to_back();
    int rb, ab, vb, sb;
    logic [7:0] got;
    rb = rx_log.size();
    ab = ack_total[1];
    vb = vrise;
    sb = sent_total;
    @(negedge clk);
    msg_q[1].push_back(8'h00); msg_q[1].push_back(8'hFF);
    wait_idle("b2b");
    checks++; if (rx_log.size() - rb != 2) begin errors++; $display("FAIL b2b_count got %0d want 2", rx_log.size() - rb); end
    got = (rb < rx_log.size()) ? rx_log[rb] : 8'hxx;
    checks++; if (got !== 8'h00) begin errors++; $display("FAIL b2b_byte0 got %h want 00", got); end
    got = (rb + 1 < rx_log.size()) ? rx_log[rb + 1] : 8'hxx;
    checks++; if (got !== 8'hFF) begin errors++; $display("FAIL b2b_byte1 got %h want ff", got); end
    checks++; if (sent_total - sb != 2) begin errors++; $display("FAIL b2b_frames got %0d want 2", sent_total - sb); end
    checks++; if (vrise - vb != 2) begin errors++; $display("FAIL b2b_valid_pulses got %0d want 2", vrise - vb); end
    checks++; if (last_gap < 1) begin errors++; $display("FAIL b2b_valid_gap got %0d want >=1", last_gap); end
    checks++; if (ack_total[1] - ab != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", ack_total[1] - ab); end
  endtask

  task automatic test_monitors();
    checks++; if (viol != 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", viol); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL frame_errors got %0d want 0", frame_err); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_early_drop();
    test_reset_load();
    test_wrap();
    test_back_to_back();
    test_monitors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
